// File: rtl/ft600_fifo_bus_model.sv
// Device-side model of the FT600 245-style synchronous FIFO bus: host words queue into RX, FPGA writes queue into TX.
// Optional macro FT_MODEL_TXE_THROTTLE_EN adds a periodic txe_n throttle pattern.
module ft600_fifo_bus_model #(
    parameter int DATA_W          = 16,
    parameter int BE_W            = 2,
    parameter int RX_AW           = 4,
    parameter int TX_AW           = 4,
    parameter int TX_MARGIN       = 1,
    parameter int THROTTLE_PERIOD = 8
) (
    input  logic                i_ft_clk,
    input  logic                rst,
    output logic                o_ft_rxf_n,
    output logic                o_ft_txe_n,
    input  logic                i_ft_oe_n,
    input  logic                i_ft_rd_n,
    input  logic                i_ft_wr_n,
    inout  wire  [DATA_W-1:0]   io_ft_data,
    inout  wire  [BE_W-1:0]     io_ft_be,
    input  logic [DATA_W-1:0]   i_h2f_data,
    input  logic                i_h2f_valid,
    output logic                o_h2f_ready,
    output logic [DATA_W-1:0]   o_f2h_data,
    output logic [BE_W-1:0]     o_f2h_be,
    output logic                o_f2h_valid,
    input  logic                i_f2h_ready,
    output logic [RX_AW:0]      o_rx_count,
    output logic [TX_AW:0]      o_tx_count,
    output logic [2:0]          o_err,
    input  logic                i_clr_err
);

    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam logic [RX_AW:0] RX_FULL = {1'b1, {RX_AW{1'b0}}};
    localparam logic [TX_AW:0] TX_FULL = {1'b1, {TX_AW{1'b0}}};

    logic [DATA_W-1:0]      r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]       r_rx_wptr;
    logic [RX_AW-1:0]       r_rx_rptr;
    logic [RX_AW:0]         r_rx_count;
    logic [RX_AW:0]         w_rx_count_next;

    logic [BE_W+DATA_W-1:0] r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]       r_tx_wptr;
    logic [TX_AW-1:0]       r_tx_rptr;
    logic [TX_AW:0]         r_tx_count;
    logic [TX_AW:0]         w_tx_count_next;
    logic [TX_AW:0]         w_tx_space;

    logic                   r_drv;
    logic                   r_rxf_n;
    logic                   r_txe_n;
    logic [2:0]             r_err;

    logic w_rx_push, w_rx_pop, w_rx_empty, w_rd_req;
    logic w_tx_wr, w_tx_push, w_tx_pop, w_tx_full;
    logic w_err_rd_empty, w_err_wr_full, w_err_conflict;
    logic w_txe_space_n, w_thr_block;
    logic [DATA_W-1:0] w_rx_head;
    logic [BE_W-1:0]   w_rx_be;

    assign w_rx_empty     = (r_rx_count == '0);
    assign o_h2f_ready    = (r_rx_count < RX_FULL);
    assign w_rx_push      = i_h2f_valid & o_h2f_ready;
    assign w_rd_req       = ~i_ft_rd_n & ~i_ft_oe_n;
    assign w_rx_pop       = w_rd_req & ~w_rx_empty;
    assign w_err_rd_empty = w_rd_req & w_rx_empty;

    // Writes ignore txe_n on purpose: the master's strobe lags txe_n by a cycle.
    assign w_tx_full      = (r_tx_count == TX_FULL);
    assign w_tx_wr        = ~i_ft_wr_n & i_ft_oe_n & (io_ft_be != '0);
    assign w_tx_push      = w_tx_wr & ~w_tx_full;
    assign w_err_wr_full  = w_tx_wr & w_tx_full;
    assign w_err_conflict = ~i_ft_wr_n & ~i_ft_oe_n;
    assign w_tx_pop       = i_f2h_ready & o_f2h_valid;

    always_comb begin
        w_rx_count_next = r_rx_count;
        if (w_rx_push && !w_rx_pop)
            w_rx_count_next = r_rx_count + (RX_AW+1)'(1);
        else if (!w_rx_push && w_rx_pop)
            w_rx_count_next = r_rx_count - (RX_AW+1)'(1);
    end

    always_comb begin
        w_tx_count_next = r_tx_count;
        if (w_tx_push && !w_tx_pop)
            w_tx_count_next = r_tx_count + (TX_AW+1)'(1);
        else if (!w_tx_push && w_tx_pop)
            w_tx_count_next = r_tx_count - (TX_AW+1)'(1);
    end

    assign w_tx_space    = TX_FULL - w_tx_count_next;
    assign w_txe_space_n = (w_tx_space <= (TX_AW+1)'(TX_MARGIN));

`ifdef FT_MODEL_TXE_THROTTLE_EN
    localparam int TH_W = (THROTTLE_PERIOD > 2) ? $clog2(THROTTLE_PERIOD) : 1;
    logic [TH_W-1:0] r_thr_cnt;
    logic [TH_W-1:0] w_thr_next;

    assign w_thr_next  = (r_thr_cnt == TH_W'(THROTTLE_PERIOD-1)) ? '0 : r_thr_cnt + TH_W'(1);
    // txe_n is registered, so the block decision looks at the counter value it will sit beside.
    assign w_thr_block = (w_thr_next >= TH_W'(THROTTLE_PERIOD-2));

    always_ff @(posedge i_ft_clk or posedge rst) begin
        if (rst) r_thr_cnt <= '0;
        else     r_thr_cnt <= w_thr_next;
    end
`else
    assign w_thr_block = 1'b0;
`endif

    always_ff @(posedge i_ft_clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= i_h2f_data;
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= {io_ft_be, io_ft_data};
    end

    always_ff @(posedge i_ft_clk or posedge rst) begin
        if (rst) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_drv      <= 1'b0;
            r_rxf_n    <= 1'b1;
            r_txe_n    <= 1'b1;
            r_err      <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_AW'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_AW'(1);
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_AW'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_AW'(1);
            r_rx_count <= w_rx_count_next;
            r_tx_count <= w_tx_count_next;
            r_drv      <= ~i_ft_oe_n;
            r_rxf_n    <= (w_rx_count_next == '0);
            r_txe_n    <= w_txe_space_n | w_thr_block;
            r_err      <= {w_err_conflict, w_err_wr_full, w_err_rd_empty}
                          | (r_err & {3{~i_clr_err}});
        end
    end

    assign w_rx_head  = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr];
    assign w_rx_be    = w_rx_empty ? '0 : {BE_W{1'b1}};
    assign io_ft_data = r_drv ? w_rx_head : {DATA_W{1'bz}};
    assign io_ft_be   = r_drv ? w_rx_be   : {BE_W{1'bz}};

    assign o_f2h_valid = (r_tx_count != '0);
    assign {o_f2h_be, o_f2h_data} = r_tx_mem[r_tx_rptr];
    assign o_rx_count  = r_rx_count;
    assign o_tx_count  = r_tx_count;
    assign o_ft_rxf_n  = r_rxf_n;
    assign o_ft_txe_n  = r_txe_n;
    assign o_err       = r_err;

endmodule

// File: tb/tb_ft600_fifo_bus_model.sv
// Directed bench for ft600_fifo_bus_model: reset, RX read, TX stream, back-pressure and error flags.
module tb_ft600_fifo_bus_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxfN, txeN;
    logic        oeN, rdN, wrN;
    logic        tbDrv;
    logic [15:0] tbData;
    logic [1:0]  tbBe;
    wire  [15:0] ftData;
    wire  [1:0]  ftBe;
    logic [15:0] h2fData;
    logic        h2fValid, h2fReady;
    logic [15:0] f2hData;
    logic [1:0]  f2hBe;
    logic        f2hValid, f2hReady;
    logic [4:0]  rxCount, txCount;
    logic [2:0]  err;
    logic        clrErr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign ftData = tbDrv ? tbData : 16'bz;
    assign ftBe   = tbDrv ? tbBe   : 2'bz;

    ft600_fifo_bus_model dut (
        .i_ft_clk    (clk),
        .rst         (rst),
        .o_ft_rxf_n  (rxfN),
        .o_ft_txe_n  (txeN),
        .i_ft_oe_n   (oeN),
        .i_ft_rd_n   (rdN),
        .i_ft_wr_n   (wrN),
        .io_ft_data  (ftData),
        .io_ft_be    (ftBe),
        .i_h2f_data  (h2fData),
        .i_h2f_valid (h2fValid),
        .o_h2f_ready (h2fReady),
        .o_f2h_data  (f2hData),
        .o_f2h_be    (f2hBe),
        .o_f2h_valid (f2hValid),
        .i_f2h_ready (f2hReady),
        .o_rx_count  (rxCount),
        .o_tx_count  (txCount),
        .o_err       (err),
        .i_clr_err   (clrErr)
    );

    task automatic test_reset();
        rst = 1'b1;
        tbDrv = 1'b1; tbData = 16'h5A5A; tbBe = 2'b10;
        repeat (3) @(negedge clk);
        checks++; if (rxfN !== 1'b1) begin errors++; $display("[TB] FAIL reset_rxf: got %b expected 1", rxfN); end
        checks++; if (txeN !== 1'b1) begin errors++; $display("[TB] FAIL reset_txe: got %b expected 1", txeN); end
        checks++; if (rxCount !== 5'd0 || txCount !== 5'd0) begin errors++; $display("[TB] FAIL reset_counts: got rx=%0d tx=%0d expected 0/0", rxCount, txCount); end
        checks++; if (err !== 3'b000) begin errors++; $display("[TB] FAIL reset_err: got %b expected 000", err); end
        checks++; if (ftData !== 16'h5A5A) begin errors++; $display("[TB] FAIL reset_bus_released: got %h expected 5a5a", ftData); end
        rst = 1'b0; tbDrv = 1'b0;
        @(negedge clk);
        checks++; if (txeN !== 1'b0) begin errors++; $display("[TB] FAIL txe_after_release: got %b expected 0", txeN); end
        checks++; if (rxfN !== 1'b1) begin errors++; $display("[TB] FAIL rxf_after_release: got %b expected 1", rxfN); end
    endtask

    task automatic test_rx_read();
        h2fData = 16'h7ABC; h2fValid = 1'b1;
        @(negedge clk);
        h2fValid = 1'b0;
        checks++; if (rxCount !== 5'd1) begin errors++; $display("[TB] FAIL rx_push_count: got %0d expected 1", rxCount); end
        checks++; if (rxfN !== 1'b0) begin errors++; $display("[TB] FAIL rx_rxf_low: got %b expected 0", rxfN); end
        oeN = 1'b0;
        @(negedge clk);
        rdN = 1'b0;
        checks++; if (ftData !== 16'h7ABC) begin errors++; $display("[TB] FAIL rx_bus_data: got %h expected 7abc", ftData); end
        checks++; if (ftBe !== 2'b11) begin errors++; $display("[TB] FAIL rx_bus_be: got %b expected 11", ftBe); end
        @(negedge clk);
        rdN = 1'b1; oeN = 1'b1;
        checks++; if (rxCount !== 5'd0) begin errors++; $display("[TB] FAIL rx_pop_count: got %0d expected 0", rxCount); end
        checks++; if (rxfN !== 1'b1) begin errors++; $display("[TB] FAIL rx_rxf_high: got %b expected 1", rxfN); end
        @(negedge clk);
    endtask

    task automatic test_rd_empty();
        oeN = 1'b0; rdN = 1'b0;
        @(negedge clk);
        rdN = 1'b1; oeN = 1'b1;
        checks++; if (err !== 3'b001) begin errors++; $display("[TB] FAIL rd_empty_err: got %b expected 001", err); end
        checks++; if (ftData !== 16'h0000 || ftBe !== 2'b00) begin errors++; $display("[TB] FAIL rd_empty_bus: got %h/%b expected 0000/00", ftData, ftBe); end
        checks++; if (rxCount !== 5'd0) begin errors++; $display("[TB] FAIL rd_empty_count: got %0d expected 0", rxCount); end
        clrErr = 1'b1;
        @(negedge clk);
        clrErr = 1'b0;
        checks++; if (err !== 3'b000) begin errors++; $display("[TB] FAIL clr_err: got %b expected 000", err); end
    endtask

    task automatic test_clr_priority();
        clrErr = 1'b1; wrN = 1'b0; oeN = 1'b0;
        @(negedge clk);
        wrN = 1'b1; oeN = 1'b1;
        checks++; if (err !== 3'b100) begin errors++; $display("[TB] FAIL conflict_beats_clr: got %b expected 100", err); end
        checks++; if (txCount !== 5'd0) begin errors++; $display("[TB] FAIL conflict_no_push: got %0d expected 0", txCount); end
        @(negedge clk);
        clrErr = 1'b0;
        checks++; if (err !== 3'b000) begin errors++; $display("[TB] FAIL conflict_cleared: got %b expected 000", err); end
        @(negedge clk);
    endtask

    task automatic test_tx_stream();
        int got = 0;
        int bad = 0;
        int txeHigh = 0;
        h2fData = 16'hA000; h2fValid = 1'b1;
        @(negedge clk);
        h2fValid = 1'b0;
        f2hReady = 1'b1;
        fork
            begin
                for (int i = 0; i < 8192; i++) begin
                    tbDrv = 1'b1; tbData = 16'(i); tbBe = 2'b11; wrN = 1'b0;
                    @(negedge clk);
                end
                wrN = 1'b1; tbDrv = 1'b0;
            end
            begin
                int cycles = 0;
                while (got < 8192 && cycles < 9000) begin
                    @(negedge clk);
                    cycles++;
                    if (txeN !== 1'b0) txeHigh++;
                    if (f2hValid === 1'b1) begin
                        if (f2hData !== 16'(got) || f2hBe !== 2'b11) bad++;
                        got++;
                    end
                end
            end
        join
        checks++; if (got !== 8192) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 8192", got); end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL stream_order: got %0d bad words expected 0", bad); end
        checks++; if (err !== 3'b000) begin errors++; $display("[TB] FAIL stream_err: got %b expected 000", err); end
`ifndef FT_MODEL_TXE_THROTTLE_EN
        checks++; if (txeHigh !== 0) begin errors++; $display("[TB] FAIL stream_txe: got %0d high cycles expected 0", txeHigh); end
`endif
        oeN = 1'b0;
        @(negedge clk);
        checks++; if (ftData !== 16'hA000) begin errors++; $display("[TB] FAIL queued_cmd: got %h expected a000", ftData); end
        rdN = 1'b0;
        @(negedge clk);
        rdN = 1'b1; oeN = 1'b1;
        checks++; if (rxCount !== 5'd0) begin errors++; $display("[TB] FAIL queued_cmd_pop: got %0d expected 0", rxCount); end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        int bad = 0;
        f2hReady = 1'b0;
        for (int i = 0; i < 17; i++) begin
`ifndef FT_MODEL_TXE_THROTTLE_EN
            if (i == 14) begin
                checks++; if (txeN !== 1'b0 || txCount !== 5'd14) begin errors++; $display("[TB] FAIL bp_14: got txe=%b cnt=%0d expected 0/14", txeN, txCount); end
            end
`endif
            if (i == 15) begin
                checks++; if (txeN !== 1'b1 || txCount !== 5'd15) begin errors++; $display("[TB] FAIL bp_15: got txe=%b cnt=%0d expected 1/15", txeN, txCount); end
            end
            tbDrv = 1'b1; tbData = 16'hB000 + 16'(i); tbBe = 2'b11; wrN = 1'b0;
            @(negedge clk);
            if (i == 15) begin
                checks++; if (txCount !== 5'd16 || err !== 3'b000) begin errors++; $display("[TB] FAIL bp_lag_write: got cnt=%0d err=%b expected 16/000", txCount, err); end
            end
        end
        wrN = 1'b1; tbDrv = 1'b0;
        checks++; if (txCount !== 5'd16 || err !== 3'b010) begin errors++; $display("[TB] FAIL bp_overflow: got cnt=%0d err=%b expected 16/010", txCount, err); end
        checks++; if (f2hData !== 16'hB000 || f2hBe !== 2'b11) begin errors++; $display("[TB] FAIL bp_head: got %h/%b expected b000/11", f2hData, f2hBe); end
        f2hReady = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (f2hValid !== 1'b1 || f2hData !== 16'hB000 + 16'(k)) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL bp_drain_order: got %0d bad words expected 0", bad); end
        checks++; if (txCount !== 5'd0 || f2hValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got cnt=%0d valid=%b expected 0/0", txCount, f2hValid); end
`ifndef FT_MODEL_TXE_THROTTLE_EN
        checks++; if (txeN !== 1'b0) begin errors++; $display("[TB] FAIL bp_txe_back: got %b expected 0", txeN); end
`endif
        f2hReady = 1'b0; clrErr = 1'b1;
        @(negedge clk);
        clrErr = 1'b0;
    endtask

    task automatic test_reset_mid();
        h2fData = 16'h1234; h2fValid = 1'b1;
        tbDrv = 1'b1; tbData = 16'h4321; tbBe = 2'b01; wrN = 1'b0;
        @(negedge clk);
        h2fValid = 1'b0; wrN = 1'b1; tbDrv = 1'b0;
        checks++; if (rxCount !== 5'd1 || txCount !== 5'd1) begin errors++; $display("[TB] FAIL mid_loaded: got rx=%0d tx=%0d expected 1/1", rxCount, txCount); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rxCount !== 5'd0 || txCount !== 5'd0 || f2hValid !== 1'b0 || rxfN !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset: got rx=%0d tx=%0d valid=%b rxf=%b expected 0/0/0/1", rxCount, txCount, f2hValid, rxfN); end
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef FT_MODEL_TXE_THROTTLE_EN
    task automatic test_throttle();
        int high = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (txeN === 1'b1) high++;
        end
        checks++; if (high !== 8) begin errors++; $display("[TB] FAIL throttle_ratio: got %0d high cycles expected 8", high); end
    endtask
`endif

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; oeN = 1'b1; rdN = 1'b1; wrN = 1'b1;
        tbDrv = 1'b0; tbData = '0; tbBe = '0;
        h2fData = '0; h2fValid = 1'b0; f2hReady = 1'b0; clrErr = 1'b0;
        test_reset();
        test_rx_read();
        test_rd_empty();
        test_clr_priority();
        test_tx_stream();
        test_back_pressure();
        test_reset_mid();
`ifdef FT_MODEL_TXE_THROTTLE_EN
        test_throttle();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ft600_fifo_bus_model.md
Name: ft600_fifo_bus_model

Overview:
Synthesizable model of the FT600 chip side of the 245-style synchronous FIFO bus. It plays the device end opposite the FPGA's bus master logic.
- Host-to-FPGA words are queued in an RX FIFO and presented through rxf_n/oe_n/rd_n.
- FPGA-to-host words written with wr_n are queued in a TX FIFO, gated by txe_n.
- Used in loopback rigs and benches to exercise command decode, ADC readout and back-pressure without silicon.

Parameters:
DATA_W, 16, FT data bus width
BE_W, 2, byte-enable width
RX_AW, 4, log2 RX FIFO depth (16 words)
TX_AW, 4, log2 TX FIFO depth (16 words)
TX_MARGIN, 1, free TX slots at or below which txe_n is raised
THROTTLE_PERIOD, 8, throttle pattern period in cycles (optional feature only)

Ports:
i_ft_clk  in  1  bus clock
rst  in  1  reset
o_ft_rxf_n  out  1  low = RX data available
o_ft_txe_n  out  1  low = TX space available
i_ft_oe_n  in  1  FPGA output-enable request
i_ft_rd_n  in  1  FPGA read strobe
i_ft_wr_n  in  1  FPGA write strobe
io_ft_data  inout  DATA_W  shared data bus
io_ft_be  inout  BE_W  shared byte enables
i_h2f_data  in  DATA_W  host word to queue
i_h2f_valid  in  1  host word valid
o_h2f_ready  out  1  RX FIFO not full
o_f2h_data  out  DATA_W  TX FIFO head data
o_f2h_be  out  BE_W  TX FIFO head byte enables
o_f2h_valid  out  1  TX FIFO not empty
i_f2h_ready  in  1  host consumes head
o_rx_count  out  RX_AW+1  RX occupancy
o_tx_count  out  TX_AW+1  TX occupancy
o_err  out  3  sticky {bus_conflict, wr_full, rd_empty}
i_clr_err  in  1  clears o_err

Behaviour:
- Reset: rst, asynchronous, active-high; clock i_ft_clk.
  - Reset values: both FIFOs empty, counts 0, o_ft_rxf_n=1, o_ft_txe_n=1, bus released, o_err=0, throttle counter 0.
  - txe_n falls on the first edge after reset release.
  - Reset mid-transfer discards all queued words.
- RX push: on a clock edge with i_h2f_valid&o_h2f_ready.
  - o_h2f_ready = (o_rx_count < 2^RX_AW), combinational.
- Bus drive: drv_q <= ~i_ft_oe_n, registered, giving one cycle of turnaround.
  - While drv_q=1: io_ft_data = RX head (all-zero if empty), io_ft_be = all-ones (all-zero if empty).
  - Otherwise both are high-Z.
- RX pop: on an edge with i_ft_rd_n=0 & i_ft_oe_n=0 & FIFO non-empty.
  - The word popped is the one the FPGA samples on that same edge.
  - Pop while empty: no pop, set err[0].
- o_ft_rxf_n <= (rx_count_next==0), registered from post-update count.
  - Simultaneous push and pop leaves the count unchanged.
- TX push: on an edge with i_ft_wr_n=0 & i_ft_oe_n=1.
  - Stores {io_ft_be, io_ft_data}; a push with be==0 is ignored.
  - Pushes are accepted whenever the FIFO is not full, regardless of txe_n, to cover the FPGA's one-cycle registered-strobe lag.
  - Push while full: word dropped, set err[1].
- i_ft_wr_n=0 with i_ft_oe_n=0: no push, set err[2].
- o_ft_txe_n <= (2^TX_AW - tx_count_next) <= TX_MARGIN.
- TX pop: on i_f2h_ready & o_f2h_valid. o_f2h_* show the head combinationally.
- FIFO pointers are RX_AW/TX_AW bits and wrap modulo depth. Counts are one bit wider, so full equals 2^AW exactly.
- i_clr_err clears o_err. An error event in the same cycle wins (bit set).

Optional Feature:
FT_MODEL_TXE_THROTTLE_EN:
- Defined: a free-running counter modulo THROTTLE_PERIOD forces o_ft_txe_n=1 during the last 2 cycles of each period, OR'ed with the space condition.
  - Write acceptance rules are unchanged, so lag writes during throttle are still stored if space remains.
- Undefined: txe_n depends on space only, and the counter is absent.

Test Plan:
- Reset release, no traffic -> rxf_n=1 throughout; txe_n=1 during reset, 0 one cycle after release; counts 0; bus high-Z.
- Host queues 0x7ABC; FPGA does oe_n low, then rd_n low next cycle -> bus shows 0x7ABC on the rd edge; rx_count 1->0; rxf_n=1 the following cycle.
- Host queues 0xA000; FPGA writes 8192 words at 0x0000..0x1FFF, host draining continuously -> host receives 8192 words in order with be=2'b11; err=0.
- Host stalls with i_f2h_ready=0; FPGA writes continuously -> txe_n rises when count reaches 15; the lag write is stored (count 16); any further write sets err[1] and the word is dropped.
- FPGA pulses rd_n with RX empty -> err[0]=1 and bus reads 0x0000; i_clr_err -> err=0.
- With FT_MODEL_TXE_THROTTLE_EN, THROTTLE_PERIOD=8 and the FIFO never filling -> txe_n high exactly 2 of every 8 cycles; all 64 words written arrive intact.
